// File: rtl/usr_frame_shifter_if.sv
// Parallel/serial bus between a controlling FSM (master) and usr_frame_shifter (slave).
// Carries manual-mode controls, frame start, serial/parallel data and frame status.
interface usr_frame_shifter_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             en;
  logic [2:0]       mode;
  logic             start;
  logic             s_in;
  logic [WIDTH-1:0] p_in;
  logic             s_out;
  logic [WIDTH-1:0] p_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output en, mode, start, s_in, p_in,
    input  s_out, p_out, busy, done, bit_cnt
  );

  modport slave (
    input  en, mode, start, s_in, p_in,
    output s_out, p_out, busy, done, bit_cnt
  );
endinterface

// File: rtl/usr_frame_shifter.sv
// Universal shift register with a WIDTH-cycle full-duplex framing engine; updates one edge after inputs,
// en=0 stalls all state. Defining USR_LSB_FIRST_EN switches framing to LSB-first (shift right, s_out=LSB).
module usr_frame_shifter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  usr_frame_shifter_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (bus.en) begin
      case (state_q)
        SHIFT: begin
`ifdef USR_LSB_FIRST_EN
          shreg_d = {bus.s_in, shreg_q[WIDTH-1:1]};
`else
          shreg_d = {shreg_q[WIDTH-2:0], bus.s_in};
`endif
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
          end
        end
        // IDLE, DONE and any unreachable encoding: start wins over manual mode
        default: begin
          if (bus.start) begin
            shreg_d = bus.p_in;
            cnt_d   = '0;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
            case (bus.mode)
              3'b001:  shreg_d = {shreg_q[WIDTH-2:0], bus.s_in};
              3'b010:  shreg_d = {bus.s_in, shreg_q[WIDTH-1:1]};
              3'b011:  shreg_d = bus.p_in;
              3'b100:  shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
              3'b101:  shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
              3'b110:  shreg_d = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
              3'b111:  shreg_d = '0;
              default: shreg_d = shreg_q;
            endcase
          end
        end
      endcase
    end
  end

`ifdef USR_LSB_FIRST_EN
  assign bus.s_out = shreg_q[0];
`else
  assign bus.s_out = shreg_q[WIDTH-1];
`endif
  assign bus.p_out   = shreg_q;
  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = (state_q == DONE);
  assign bus.bit_cnt = cnt_q;
endmodule

// File: tb/tb_usr_frame_shifter.sv
// Directed bench for usr_frame_shifter (WIDTH=8): manual-mode vector table plus framing sequences.
module tb_usr_frame_shifter;
  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic       start;
  logic       s_in;
  logic [7:0] p_in;

  int total  = 0;
  int passed = 0;

  usr_frame_shifter_if #(.WIDTH(8)) bus ();

  assign bus.en    = en;
  assign bus.mode  = mode;
  assign bus.start = start;
  assign bus.s_in  = s_in;
  assign bus.p_in  = p_in;

  usr_frame_shifter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic       s_in;
    logic [7:0] p_in;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int bi(input int k);
`ifdef USR_LSB_FIRST_EN
    return k;
`else
    return 7 - k;
`endif
  endfunction

  // One frame; stall_at/abort_at name the bit_cnt value after which the stall or reset happens (0 = none)
  task automatic frame(input logic [7:0] tx, input logic [7:0] rx, input int stall_at, input int abort_at);
    start = 1'b1; p_in = tx; mode = 3'b111; en = 1'b1;
    step();
    start = 1'b0; mode = 3'b000;
    chk("frame_load", 64'(bus.p_out), 64'(tx));
    chk("frame_busy_start", 64'(bus.busy), 64'd1);
    chk("frame_cnt_start", 64'(bus.bit_cnt), 64'd0);
    for (int k = 0; k < 8; k++) begin
      chk("tx_bit", 64'(bus.s_out), 64'(tx[bi(k)]));
      s_in = rx[bi(k)];
      if (k == 3) begin
        start = 1'b1; p_in = 8'hFF; mode = 3'b111;
      end
      step();
      start = 1'b0; mode = 3'b000;
      chk("bit_cnt", 64'(bus.bit_cnt), 64'(k + 1));
      chk("busy", 64'(bus.busy), 64'(k < 7));
      chk("done", 64'(bus.done), 64'(k == 7));
      if (k + 1 == stall_at) begin
        en = 1'b0;
        repeat (3) begin
          s_in = ~s_in;
          step();
          chk("stall_cnt", 64'(bus.bit_cnt), 64'(k + 1));
          chk("stall_s_out", 64'(bus.s_out), 64'(tx[bi(k + 1)]));
          chk("stall_busy", 64'(bus.busy), 64'd1);
        end
        en = 1'b1;
      end
      if (k + 1 == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_p_out", 64'(bus.p_out), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_cnt", 64'(bus.bit_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("abort_no_done", 64'(bus.done), 64'd0);
        chk("abort_idle_busy", 64'(bus.busy), 64'd0);
        return;
      end
    end
    chk("frame_rx", 64'(bus.p_out), 64'(rx));
  endtask

  initial begin
    vecs[0]  = '{3'b011, 1'b0, 8'hA5, 8'hA5};
    vecs[1]  = '{3'b001, 1'b1, 8'h00, 8'h4B};
    vecs[2]  = '{3'b000, 1'b0, 8'hFF, 8'h4B};
    vecs[3]  = '{3'b111, 1'b1, 8'hFF, 8'h00};
    vecs[4]  = '{3'b011, 1'b0, 8'h81, 8'h81};
    vecs[5]  = '{3'b101, 1'b0, 8'h00, 8'hC0};
    vecs[6]  = '{3'b100, 1'b0, 8'h00, 8'h81};
    vecs[7]  = '{3'b011, 1'b0, 8'h90, 8'h90};
    vecs[8]  = '{3'b110, 1'b0, 8'h00, 8'hC8};
    vecs[9]  = '{3'b010, 1'b0, 8'h00, 8'h64};
    vecs[10] = '{3'b010, 1'b1, 8'h00, 8'hB2};
    vecs[11] = '{3'b001, 1'b0, 8'h00, 8'h64};

    rst_n = 1'b1; en = 1'b0; mode = 3'b000; start = 1'b0; s_in = 1'b0; p_in = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_p_out", 64'(bus.p_out), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_cnt", 64'(bus.bit_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    en = 1'b1;

    foreach (vecs[i]) begin
      mode = vecs[i].mode; s_in = vecs[i].s_in; p_in = vecs[i].p_in;
      step();
      chk("manual_mode", 64'(bus.p_out), 64'(vecs[i].exp));
    end

    // en=0 in manual mode must hold the register
    en = 1'b0; mode = 3'b111;
    step();
    chk("manual_en_hold", 64'(bus.p_out), 64'h64);
    en = 1'b1; mode = 3'b000;

    frame(8'hA5, 8'h3C, 0, 0);
    // back-to-back: start accepted while done is high
    frame(8'h5A, 8'hC3, 4, 0);
    en = 1'b0;
    step();
    chk("done_stretch", 64'(bus.done), 64'd1);
    chk("done_cnt_hold", 64'(bus.bit_cnt), 64'd8);
    en = 1'b1;
    step();
    chk("done_clear", 64'(bus.done), 64'd0);
    chk("idle_cnt_hold", 64'(bus.bit_cnt), 64'd8);
    chk("idle_rx_hold", 64'(bus.p_out), 64'hC3);
    step();
    frame(8'hF0, 8'h0F, 0, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/usr_frame_shifter.md
Name: usr_frame_shifter

Overview:
- Parametrised successor to the 4-bit universal shift register.
- WIDTH-bit register with eight manual modes: hold, logical shifts, rotates, arithmetic shift, parallel load, clear.
- Adds an automatic framing engine: a `start` pulse loads a word, then shifts it out serially for exactly WIDTH cycles while capturing serial input (full-duplex, SPI-style).
- Sits between parallel datapath logic and serial links. It provides `busy`/`done` status and a bit counter to the controlling FSM.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- CNT_W, localparam = $clog2(WIDTH+1), bit-counter width; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  clock enable; when 0, all state (register, FSM, counter, done) holds
- mode  input  3  manual operation select; honoured only in IDLE with start=0
- start  input  1  single-cycle request to begin an automatic frame
- s_in  input  1  serial input bit
- p_in  input  WIDTH  parallel load data
- s_out  output  1  serial output = shift_reg[WIDTH-1] (LSB-first build: shift_reg[0])
- p_out  output  WIDTH  shift_reg contents
- busy  output  1  high while a frame is shifting
- done  output  1  one-cycle pulse after the final frame shift
- bit_cnt  output  CNT_W  number of shifts completed in the current frame

Behaviour:
- Reset (rst_n=0, asynchronous):
  - shift_reg=0, state=IDLE, busy=0, done=0, bit_cnt=0.
  - Reset mid-frame aborts the frame immediately; no done pulse.
- All updates occur on the rising clk edge and only when en=1. s_out and p_out are combinational from shift_reg.
- Manual modes (state IDLE or DONE, start=0, en=1):
  - 000 hold
  - 001 shift left, s_in→LSB
  - 010 shift right, s_in→MSB
  - 011 load p_in
  - 100 rotate left
  - 101 rotate right
  - 110 arithmetic shift right (MSB replicated)
  - 111 clear to 0
- FSM states: IDLE, SHIFT, DONE.
  - IDLE/DONE + start=1:
    - shift_reg←p_in, bit_cnt←0, state→SHIFT, busy←1.
    - start takes priority over mode.
  - SHIFT (each enabled edge):
    - Shift left, s_in→LSB; bit_cnt←bit_cnt+1.
    - On the edge where bit_cnt becomes WIDTH: state→DONE, busy←0, done←1.
  - DONE:
    - done=1 for exactly one enabled cycle, then →IDLE with done←0, unless start is accepted, which gives back-to-back frames.
    - bit_cnt holds WIDTH until the next start.
- busy is high for exactly WIDTH enabled cycles per frame. s_out presents bits MSB-first, one per cycle, starting the cycle after start.
- start while busy: ignored. mode while busy: ignored.
- en=0 mid-frame: stalls without losing or duplicating bits; bit_cnt frozen; the done pulse is stretched until the next enabled edge.
- After a frame completes, p_out holds the WIDTH bits sampled on s_in, first-sampled bit in the MSB.

Optional Feature:
- Macro USR_LSB_FIRST_EN.
- Defined:
  - Frame shifting is shift-right with s_in→MSB.
  - s_out = shift_reg[0]; bits are transmitted LSB-first.
  - The received word has the first-sampled bit in the LSB.
  - Manual modes are unchanged.
- Undefined: MSB-first framing as described above.

Test Plan (WIDTH=8, feature undefined unless noted):
1. Reset with rst_n=0, no clock edge → p_out=0x00, busy=0, done=0, bit_cnt=0 asynchronously.
2. mode=011 with p_in=0xA5 → 0xA5; then mode=001 with s_in=1 → 0x4B; mode=000 → holds 0x4B; mode=111 → 0x00.
3. Load 0x81, then mode=101 → 0xC0; mode=100 → 0x81; load 0x90, then mode=110 → 0xC8; mode=010 with s_in=0 → 0x64.
4. start with p_in=0xA5, s_in driven MSB-first with 0x3C:
   - s_out sequence is 1,0,1,0,0,1,0,1.
   - busy is high 8 cycles; bit_cnt steps 1..8.
   - done pulses once; final p_out=0x3C.
   - start re-asserted mid-frame has no effect.
5. Frame with en=0 for 3 cycles after bit 4 → bit_cnt stays 4, s_out unchanged; resumes and completes with the correct 8 bits. Then rst_n low after bit 5 of a new frame → immediate clear, no done.
6. With USR_LSB_FIRST_EN: start with p_in=0xA5, s_in driven LSB-first with 0x3C → s_out sequence 1,0,1,0,0,1,0,1; final p_out=0x3C.
